// File: rtl/hazard_pkg.sv
// Shared types and encodings for the decode-stage hazard controller.
// Opcodes, forwarding-select encodings and the in-flight table entry layout.
package hazard_pkg;

    localparam int REG_W = 5;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    // Table slots, youngest first; only EX and MEM can create hazards.
    localparam int STG_EX  = 0;
    localparam int STG_MEM = 1;
    localparam int N_STG   = 3;
    localparam int N_HAZ   = 2;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             wen;
        logic             is_load;
    } entry_t;

    // EX-slot match wins over MEM-slot match: it holds the younger value.
    function automatic logic [1:0] fwd_sel(input logic hit_ex, input logic hit_mem);
        if (hit_ex)
            return FWD_EXMEM;
        else if (hit_mem)
            return FWD_MEMWB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/instr_reg_use.sv
// Opcode classifier: which register fields an instruction reads/writes.
module instr_reg_use
    import hazard_pkg::*;
(
    input  logic [6:0] opcode,
    output logic       uses_rs1,
    output logic       uses_rs2,
    output logic       wen,
    output logic       is_load
);

    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        wen      = 1'b0;
        is_load  = 1'b0;
        case (opcode)
            OPC_OP: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                wen      = 1'b1;
            end
            OPC_OP_IMM: begin
                uses_rs1 = 1'b1;
                wen      = 1'b1;
            end
            OPC_LOAD: begin
                uses_rs1 = 1'b1;
                wen      = 1'b1;
                is_load  = 1'b1;
            end
            OPC_STORE, OPC_BRANCH: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OPC_JALR: begin
                uses_rs1 = 1'b1;
                wen      = 1'b1;
            end
            OPC_LUI, OPC_JAL: begin
                wen = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage interlock/bypass controller tracking EX/MEM/WB destinations.
// Define HAZARD_FWD_EN for bypass selects; otherwise every RAW hazard stalls.
module hazard_ctrl
    import hazard_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [6:0]       id_opcode,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic [REG_W-1:0] id_rd,
    input  logic             ex_branch_taken,
    output logic             stall,
    output logic             flush_id,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [31:0]      stall_cnt
);

    logic dec_uses_rs1;
    logic dec_uses_rs2;
    logic dec_wen;
    logic dec_is_load;

    instr_reg_use u_dec (
        .opcode   (id_opcode),
        .uses_rs1 (dec_uses_rs1),
        .uses_rs2 (dec_uses_rs2),
        .wen      (dec_wen),
        .is_load  (dec_is_load)
    );

    entry_t           tbl_reg [N_STG];
    entry_t           id_entry;
    logic [N_HAZ-1:0] hit_rs1;
    logic [N_HAZ-1:0] hit_rs2;
    logic             stall_raw;
    logic             advance;
    logic [31:0]      stall_cnt_reg;

    assign id_entry = '{valid: 1'b1, rd: id_rd, wen: dec_wen, is_load: dec_is_load};

    genvar gi;
    generate
        for (gi = 0; gi < N_HAZ; gi++) begin : g_match
            assign hit_rs1[gi] = id_valid & dec_uses_rs1 & tbl_reg[gi].valid & tbl_reg[gi].wen
                               & (tbl_reg[gi].rd != '0) & (tbl_reg[gi].rd == id_rs1);
            assign hit_rs2[gi] = id_valid & dec_uses_rs2 & tbl_reg[gi].valid & tbl_reg[gi].wen
                               & (tbl_reg[gi].rd != '0) & (tbl_reg[gi].rd == id_rs2);
        end
    endgenerate

`ifdef HAZARD_FWD_EN
    // Only a load result is unavailable for bypass from the EX slot.
    assign stall_raw = tbl_reg[STG_EX].is_load & (hit_rs1[STG_EX] | hit_rs2[STG_EX]);
`else
    assign stall_raw = (|hit_rs1) | (|hit_rs2);
`endif

    // A redirect squashes the decode slot, so holding it would be pointless.
    assign flush_id = ex_branch_taken;
    assign stall    = stall_raw & ~flush_id;
    assign advance  = id_valid & ~stall & ~flush_id;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tbl_reg[STG_EX] <= '0;
        else
            tbl_reg[STG_EX] <= advance ? id_entry : '0;
    end

    generate
        for (gi = 1; gi < N_STG; gi++) begin : g_shift
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    tbl_reg[gi] <= '0;
                else
                    tbl_reg[gi] <= tbl_reg[gi-1];
            end
        end
    endgenerate

`ifdef HAZARD_FWD_EN
    logic [1:0] fwd_a_reg;
    logic [1:0] fwd_b_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_a_reg <= FWD_RF;
            fwd_b_reg <= FWD_RF;
        end else if (advance) begin
            fwd_a_reg <= fwd_sel(hit_rs1[STG_EX], hit_rs1[STG_MEM]);
            fwd_b_reg <= fwd_sel(hit_rs2[STG_EX], hit_rs2[STG_MEM]);
        end else begin
            fwd_a_reg <= FWD_RF;
            fwd_b_reg <= FWD_RF;
        end
    end

    assign fwd_a = fwd_a_reg;
    assign fwd_b = fwd_b_reg;
`else
    assign fwd_a = FWD_RF;
    assign fwd_b = FWD_RF;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt_reg <= '0;
        else if (stall && (stall_cnt_reg != '1))
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end

    assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; expectations follow HAZARD_FWD_EN.
module tb_hazard_ctrl;

`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct packed {
        logic [6:0] op;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } instr_t;

    localparam logic [6:0] OP   = 7'b0110011;
    localparam logic [6:0] OPI  = 7'b0010011;
    localparam logic [6:0] LD   = 7'b0000011;
    localparam logic [6:0] BR   = 7'b1100011;
    localparam logic [6:0] LUI  = 7'b0110111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [6:0]  id_opcode;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        ex_branch_taken;
    logic        stall, flush_id;
    logic [1:0]  fwd_a, fwd_b;
    logic [31:0] stall_cnt;

    int errors = 0;
    int checks = 0;
    int exp_cnt = 0;

    hazard_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_valid        (id_valid),
        .id_opcode       (id_opcode),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_rd           (id_rd),
        .ex_branch_taken (ex_branch_taken),
        .stall           (stall),
        .flush_id        (flush_id),
        .fwd_a           (fwd_a),
        .fwd_b           (fwd_b),
        .stall_cnt       (stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic instr_t mk(input logic [6:0] op, input logic [4:0] rd,
                                  input logic [4:0] rs1, input logic [4:0] rs2);
        return '{op: op, rs1: rs1, rs2: rs2, rd: rd};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input instr_t in, input logic v, input logic br);
        id_valid        = v;
        id_opcode       = in.op;
        id_rs1          = in.rs1;
        id_rs2          = in.rs2;
        id_rd           = in.rd;
        ex_branch_taken = br;
        #1;
    endtask

    task automatic idle(input int n);
        set_id('0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Producer, optional NOP gap, consumer; counts consumer stall cycles (bounded).
    task automatic run_seq(input string tag, input instr_t prod, input bit gap,
                           input instr_t cons, input int exp_stalls,
                           input logic [1:0] exp_a, input logic [1:0] exp_b);
        int n;
        set_id(prod, 1'b1, 1'b0);
        chk({tag, ".prod_stall"}, 32'(stall), 32'd0);
        tick();
        if (gap) begin
            set_id(mk(OPI, 5'd0, 5'd0, 5'd0), 1'b1, 1'b0);
            tick();
        end
        set_id(cons, 1'b1, 1'b0);
        n = 0;
        while (stall && n < 6) begin
            n++;
            tick();
        end
        chk({tag, ".stalls"}, 32'(n), 32'(exp_stalls));
        tick();
        set_id('0, 1'b0, 1'b0);
        chk({tag, ".fwd_a"}, 32'(fwd_a), 32'(exp_a));
        chk({tag, ".fwd_b"}, 32'(fwd_b), 32'(exp_b));
        exp_cnt += exp_stalls;
        chk({tag, ".stall_cnt"}, stall_cnt, 32'(exp_cnt));
        $display("txn %s: stalls=%0d fwd_a=%0d fwd_b=%0d stall_cnt=%0d",
                 tag, n, fwd_a, fwd_b, stall_cnt);
        idle(3);
    endtask

    initial begin
        rst_n = 1'b0;
        set_id('0, 1'b0, 1'b0);
        chk("reset.stall", 32'(stall), 32'd0);
        chk("reset.flush", 32'(flush_id), 32'd0);
        chk("reset.fwd_a", 32'(fwd_a), 32'd0);
        chk("reset.fwd_b", 32'(fwd_b), 32'd0);
        chk("reset.cnt", stall_cnt, 32'd0);
        tick();
        rst_n = 1'b1;
        idle(2);

        // lw x5,0(x1); add x6,x5,x2
        run_seq("load_use", mk(LD, 5'd5, 5'd1, 5'd0), 1'b0, mk(OP, 5'd6, 5'd5, 5'd2),
                FWD ? 1 : 2, FWD ? 2'b10 : 2'b00, 2'b00);
        // add x3,x1,x2; sub x4,x3,x3
        run_seq("alu_chain", mk(OP, 5'd3, 5'd1, 5'd2), 1'b0, mk(OP, 5'd4, 5'd3, 5'd3),
                FWD ? 0 : 2, FWD ? 2'b01 : 2'b00, FWD ? 2'b01 : 2'b00);
        // add x3,x1,x2; nop; or x7,x3,x0
        run_seq("dist2", mk(OP, 5'd3, 5'd1, 5'd2), 1'b1, mk(OP, 5'd7, 5'd3, 5'd0),
                FWD ? 0 : 1, FWD ? 2'b10 : 2'b00, 2'b00);
        // lw x0,0(x1); add x6,x0,x0
        run_seq("x0_dest", mk(LD, 5'd0, 5'd1, 5'd0), 1'b0, mk(OP, 5'd6, 5'd0, 5'd0),
                0, 2'b00, 2'b00);
        // lui x8; lui x9 whose rs1 field happens to be 8: LUI reads nothing
        run_seq("lui_no_use", mk(LUI, 5'd8, 5'd0, 5'd0), 1'b0, mk(LUI, 5'd9, 5'd8, 5'd8),
                0, 2'b00, 2'b00);
        // addi x10,x1,1; beq x11,x10: branch reads rs2
        run_seq("branch_rs2", mk(OPI, 5'd10, 5'd1, 5'd0), 1'b0, mk(BR, 5'd0, 5'd11, 5'd10),
                FWD ? 0 : 2, 2'b00, FWD ? 2'b01 : 2'b00);

        // Flush in the cycle a load-use stall would occur
        set_id(mk(LD, 5'd5, 5'd1, 5'd0), 1'b1, 1'b0);
        tick();
        set_id(mk(OP, 5'd6, 5'd5, 5'd2), 1'b1, 1'b1);
        chk("flush.flush_id", 32'(flush_id), 32'd1);
        chk("flush.stall", 32'(stall), 32'd0);
        tick();
        set_id(mk(OP, 5'd7, 5'd6, 5'd6), 1'b1, 1'b0);
        chk("flush.bubble_fwd_a", 32'(fwd_a), 32'd0);
        chk("flush.bubble_fwd_b", 32'(fwd_b), 32'd0);
        chk("flush.squashed_no_stall", 32'(stall), 32'd0);
        tick();
        set_id('0, 1'b0, 1'b0);
        chk("flush.squashed_fwd_a", 32'(fwd_a), 32'd0);
        chk("flush.cnt", stall_cnt, 32'(exp_cnt));
        $display("txn flush: flush_id=1 fwd_a=%0d stall_cnt=%0d", fwd_a, stall_cnt);
        idle(3);

        // Reset pulse while a consumer is held in ID
        set_id(mk(OP, 5'd3, 5'd1, 5'd2), 1'b1, 1'b0);
        tick();
        set_id(mk(OP, 5'd4, 5'd3, 5'd3), 1'b1, 1'b0);
        chk("rst.pre_stall", 32'(stall), FWD ? 32'd0 : 32'd1);
        chk("rst.pre_cnt_nonzero", 32'(stall_cnt != 0), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst.stall", 32'(stall), 32'd0);
        chk("rst.fwd_a", 32'(fwd_a), 32'd0);
        chk("rst.fwd_b", 32'(fwd_b), 32'd0);
        chk("rst.cnt", stall_cnt, 32'd0);
        #2;
        rst_n = 1'b1;
        #1;
        chk("rst.post_stall", 32'(stall), 32'd0);
        tick();
        set_id('0, 1'b0, 1'b0);
        chk("rst.post_fwd_a", 32'(fwd_a), 32'd0);
        chk("rst.post_cnt", stall_cnt, 32'd0);
        $display("txn reset: stall=%0d fwd_a=%0d stall_cnt=%0d", stall, fwd_a, stall_cnt);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
